// File: rtl/bfm_xmtr_if.sv
// Stream bundle between the bfm_xmtr transmitter and its sink.
// Handshake: the source raises tx_vld with tx_data and holds both steady
// until tx_rdy is seen high at a posedge. A beat moves only when
// tx_vld & tx_rdy are both 1 at that posedge. tx_rdy has no effect while
// tx_vld is 0. tx_busy is 1 while a burst is in progress.
interface bfm_xmtr_if;
  logic [127:0] tx_data;
  logic         tx_vld;
  logic         tx_rdy;
  logic         tx_busy;

  modport master (
    output tx_data,
    output tx_vld,
    output tx_busy,
    input  tx_rdy
  );

  modport slave (
    input  tx_data,
    input  tx_vld,
    input  tx_busy,
    output tx_rdy
  );
endinterface

// File: rtl/bfm_xmtr.sv
// bfm_xmtr: transmit-side stream model used in simulation.
// It sends a burst of cfg_length beats. Beat k carries DATA_BASE + k, and the
// sum wraps at 128 bits. A burst can start after a delay. A random pause can
// follow each beat. The model is set up and started only through the tasks
// setcfg_length, setcfg_pause, setcfg_pause_rate and start.
// Define BFM_XMTR_LOG_EN to print one line per transfer. The cycle behaviour
// does not change when it is defined.
module bfm_xmtr #(
  parameter string        NAME      = "Transmitter",
  parameter logic [127:0] DATA_BASE = 128'h0
) (
  input  logic             clk,
  input  logic             rst,
  bfm_xmtr_if.master       bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  state_e state_q;
  state_e state_d;

  // Configuration. Only the tasks below write these registers, and reset
  // leaves them unchanged.
  logic [31:0] cfg_length      = 32'd0;
  logic        cfg_pause_en    = 1'b0;
  logic [31:0] cfg_pause_cycle = 32'd0;
  logic        run_en          = 1'b0;
  logic [31:0] wait_cycle      = 32'd0;

  // Run-time counters
  logic [31:0]  cnt_clk;
  logic [31:0]  cnt_data;
  logic [31:0]  cnt_hold;
  logic [31:0]  pause_cycle;
  logic [127:0] data_q;

  logic xfer;
  logic last_beat;

  assign xfer      = (state_q == ST_SEND) && bus.tx_rdy;
  assign last_beat = xfer && (cnt_data == cfg_length - 32'd1);

  assign bus.tx_vld  = (state_q == ST_SEND);
  assign bus.tx_busy = (state_q != ST_IDLE);
  assign bus.tx_data = data_q;
  assign dbg_state   = state_q;

  // Next-state logic for the burst FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run_en && (cfg_length != 32'd0)) begin
          state_d = (wait_cycle != 32'd0) ? ST_WAIT : ST_SEND;
        end
      end
      ST_WAIT: begin
        if (cnt_clk == wait_cycle - 32'd1) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else if (cfg_pause_en) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_hold == pause_cycle) begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, counters, payload and pause draw
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_clk     <= 32'd0;
      cnt_data    <= 32'd0;
      cnt_hold    <= 32'd0;
      pause_cycle <= 32'd0;
      data_q      <= DATA_BASE;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (run_en) begin
            cnt_clk  <= 32'd0;
            cnt_data <= 32'd0;
            cnt_hold <= 32'd0;
            data_q   <= DATA_BASE;
          end
        end
        ST_WAIT: begin
          cnt_clk <= cnt_clk + 32'd1;
        end
        ST_SEND: begin
          if (xfer) begin
`ifdef BFM_XMTR_LOG_EN
            $display("%0t: %s beat %0d data %h", $time, NAME, cnt_data, data_q);
`endif
            cnt_data <= cnt_data + 32'd1;
            data_q   <= data_q + 128'd1;
            cnt_hold <= 32'd0;
            if (cfg_pause_en) begin
              // A rate of zero gives a one-cycle gap and avoids a modulo by zero
              pause_cycle <= (cfg_pause_cycle == 32'd0) ? 32'd0
                                                        : ({$random} % cfg_pause_cycle);
            end
            if (last_beat) begin
              $display("%0t: %s burst done, %0d beats", $time, NAME, cnt_data + 32'd1);
            end
          end
        end
        ST_HOLD: begin
          if (cnt_hold != pause_cycle) begin
            cnt_hold <= cnt_hold + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Configuration tasks. Each one waits for a posedge and then updates its register.
  task automatic setcfg_length(input logic [31:0] len);
    @(posedge clk);
    cfg_length <= len;
    $display("%0t: %s cfg_length = %0d", $time, NAME, len);
  endtask

  task automatic setcfg_pause(input logic en);
    @(posedge clk);
    cfg_pause_en <= en;
    $display("%0t: %s cfg_pause_en = %0d", $time, NAME, en);
  endtask

  task automatic setcfg_pause_rate(input logic [31:0] cyc);
    @(posedge clk);
    cfg_pause_cycle <= cyc;
    $display("%0t: %s cfg_pause_cycle = %0d", $time, NAME, cyc);
  endtask

  // run_en is a single-cycle pulse. wait_cycle holds the start delay for the burst.
  task automatic start(input logic en, input logic [31:0] wait_cyc);
    @(posedge clk);
    run_en     <= en;
    wait_cycle <= wait_cyc;
    $display("%0t: %s start run_en=%0d wait_cycle=%0d", $time, NAME, en, wait_cyc);
    @(posedge clk);
    run_en <= 1'b0;
  endtask

endmodule

// File: tb/tb_bfm_xmtr.sv
// Directed bench for bfm_xmtr. The bench samples outputs on the negedge and
// changes inputs away from the posedge.
module tb_bfm_xmtr;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state2;

  bfm_xmtr_if bus ();
  bfm_xmtr_if bus2 ();

  bfm_xmtr #(.NAME("Transmitter"), .DATA_BASE(128'h0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  bfm_xmtr #(.NAME("WrapXmtr"), .DATA_BASE({128{1'b1}})) dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .dbg_state (dbg_state2)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] got_q[$];
  int           gap_q[$];
  int           lead;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Records the beats on bus until tx_busy drops. It also records the number of
  // idle negedges before the first beat (lead) and between beats (gap_q).
  task automatic collect(input string tag, input int budget);
    int  gap;
    bit  seen;
    bit  done;
    got_q.delete();
    gap_q.delete();
    gap  = 0;
    seen = 0;
    done = 0;
    lead = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!bus.tx_busy) begin
        done = 1;
      end else if (bus.tx_vld && bus.tx_rdy) begin
        got_q.push_back(bus.tx_data);
        if (seen) gap_q.push_back(gap);
        gap  = 0;
        seen = 1;
      end else if (seen) begin
        gap++;
      end else begin
        lead++;
      end
    end
    check({tag, "_finished"}, 128'(done), 128'd1);
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    end
  endtask

  task automatic load_exp(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(128'(i));
  endtask

  initial begin
    int found;
    rst         = 1'b1;
    bus.tx_rdy  = 1'b0;
    bus2.tx_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_vld",   128'(bus.tx_vld), 128'd0);
    check("rst_busy",  128'(bus.tx_busy), 128'd0);
    check("rst_data",  bus.tx_data, 128'd0);
    check("rst_state", 128'(dbg_state), 128'd0);

    // A burst with length 0 never leaves IDLE
    bus.tx_rdy = 1'b1;
    dut.start(1'b1, 32'd0);
    @(negedge clk);
    check("len0_busy", 128'(bus.tx_busy), 128'd0);
    @(negedge clk);
    check("len0_busy2", 128'(bus.tx_busy), 128'd0);

    // Four beats sent back to back with no delay
    dut.setcfg_length(32'd4);
    dut.setcfg_pause(1'b0);
    dut.start(1'b1, 32'd0);
    collect("b2b", 100);
    load_exp(4);
    compare_beats("b2b");
    check("b2b_lead", 128'(lead), 128'd0);
    for (int i = 0; i < gap_q.size(); i++) check($sformatf("b2b_gap%0d", i), 128'(gap_q[i]), 128'd0);
    check("b2b_busy_end", 128'(bus.tx_busy), 128'd0);

    // The start delay gives exactly five WAIT cycles
    dut.setcfg_length(32'd3);
    dut.start(1'b1, 32'd5);
    @(negedge clk);
    check("wait_busy", 128'(bus.tx_busy), 128'd1);
    check("wait_state", 128'(dbg_state), 128'd1);
    collect("wait", 100);
    check("wait_lead", 128'(lead + 1), 128'd5);
    load_exp(3);
    compare_beats("wait");

    // A stalled beat holds its data
    dut.setcfg_length(32'd2);
    bus.tx_rdy = 1'b0;
    dut.start(1'b1, 32'd0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("stall_vld%0d", i), 128'(bus.tx_vld), 128'd1);
      check($sformatf("stall_data%0d", i), bus.tx_data, 128'd0);
    end
    @(posedge clk);
    #1 bus.tx_rdy = 1'b1;
    collect("stall", 100);
    load_exp(2);
    compare_beats("stall");

    // Random pauses: each gap is 1..4 cycles
    dut.setcfg_length(32'd10);
    dut.setcfg_pause(1'b1);
    dut.setcfg_pause_rate(32'd4);
    dut.start(1'b1, 32'd0);
    collect("pause", 400);
    load_exp(10);
    compare_beats("pause");
    check("pause_ngaps", 128'(gap_q.size()), 128'd9);
    for (int i = 0; i < gap_q.size(); i++)
      check($sformatf("pause_gap%0d", i), 128'(gap_q[i] >= 1 && gap_q[i] <= 4), 128'd1);

    // A rate of 0 gives one-cycle gaps
    dut.setcfg_length(32'd3);
    dut.setcfg_pause_rate(32'd0);
    dut.start(1'b1, 32'd0);
    collect("rate0", 100);
    load_exp(3);
    compare_beats("rate0");
    for (int i = 0; i < gap_q.size(); i++) check($sformatf("rate0_gap%0d", i), 128'(gap_q[i]), 128'd1);

    // Reset in the middle of a burst, then a fresh burst
    dut.setcfg_pause(1'b0);
    dut.setcfg_length(32'd8);
    dut.start(1'b1, 32'd0);
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk);
      if (bus.tx_vld && bus.tx_data == 128'd2) found = 1;
    end
    check("mid_found_beat2", 128'(found), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_vld",  128'(bus.tx_vld), 128'd0);
    check("mid_rst_busy", 128'(bus.tx_busy), 128'd0);
    check("mid_rst_data", bus.tx_data, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_idle_busy", 128'(bus.tx_busy), 128'd0);
    dut.start(1'b1, 32'd0);
    collect("restart", 100);
    load_exp(8);
    compare_beats("restart");

    // Data wraps at 128 bits
    dut2.setcfg_length(32'd2);
    dut2.start(1'b1, 32'd0);
    @(negedge clk);
    check("wrap_vld0",  128'(bus2.tx_vld), 128'd1);
    check("wrap_data0", bus2.tx_data, {128{1'b1}});
    @(negedge clk);
    check("wrap_vld1",  128'(bus2.tx_vld), 128'd1);
    check("wrap_data1", bus2.tx_data, 128'd0);
    @(negedge clk);
    check("wrap_end_vld",  128'(bus2.tx_vld), 128'd0);
    check("wrap_end_busy", 128'(bus2.tx_busy), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
